// File: rtl/parameter_loader.sv
// Byte-stream parameter loader: decodes WRITE/COMMIT packets from a host byte stream,
// strobes one parameter buffer per WRITE and issues a frame-aligned buffer switch per COMMIT.
module parameter_loader #(
  parameter int DATA_WIDTH   = 36,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  input  logic                    frame_start,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [NUM_CHANNELS-1:0] write_enable,
  output logic                    buffer_switch_event,
  output logic                    switch_pending,
  output logic                    error
);

  localparam int NB = (DATA_WIDTH + 7) / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    WRITE   = 2'd2,
    PENDING = 2'd3
  } state_t;

  state_t                  state, state_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [1:0]              ch, ch_nx;
  logic [DATA_WIDTH-1:0]   shift, shift_nx;
  logic [DATA_WIDTH-1:0]   write_data_nx;
  logic [NUM_CHANNELS-1:0] write_enable_nx;
  logic                    bse_nx, pend_nx, err_nx, ready_nx;
  logic                    accept;

  function automatic logic is_write_header(input logic [7:0] b);
    return (b[7:2] == 6'b100000);
  endfunction

  function automatic logic channel_ok(input logic [1:0] cc);
    return (int'(cc) < NUM_CHANNELS);
  endfunction

  function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [1:0] sel);
    logic [NUM_CHANNELS-1:0] v;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      v[i] = (int'(sel) == i);
    end
    return v;
  endfunction

  assign accept = rx_valid & rx_ready;

  // Next-state and next-output decode; bytes beyond DATA_WIDTH fall off the top of the shifter.
  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    ch_nx           = ch;
    shift_nx        = shift;
    write_data_nx   = write_data;
    write_enable_nx = {NUM_CHANNELS{1'b0}};
    bse_nx          = 1'b0;
    err_nx          = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_write_header(rx_data) && channel_ok(rx_data[1:0])) begin
            ch_nx    = rx_data[1:0];
            cnt_nx   = {CW{1'b0}};
            state_nx = PAYLOAD;
          end else if (rx_data == 8'hC0) begin
            state_nx = PENDING;
          end else begin
            err_nx   = 1'b1;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      PAYLOAD: begin
        if (accept) begin
          shift_nx = (shift << 4'd8) | DATA_WIDTH'(rx_data);
          if (cnt == CW'(NB - 1)) begin
            cnt_nx          = {CW{1'b0}};
            write_data_nx   = shift_nx;
            write_enable_nx = onehot(ch);
            state_nx        = WRITE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end else begin
          state_nx = PAYLOAD;
        end
      end
      WRITE: begin
        state_nx = IDLE;
      end
      PENDING: begin
        if (frame_start) begin
          bse_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = PENDING;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    ready_nx = (state_nx == IDLE) || (state_nx == PAYLOAD);
    pend_nx  = (state_nx == PENDING);
  end

  // State and registered outputs; rx_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      cnt                 <= {CW{1'b0}};
      ch                  <= 2'd0;
      shift               <= {DATA_WIDTH{1'b0}};
      write_data          <= {DATA_WIDTH{1'b0}};
      write_enable        <= {NUM_CHANNELS{1'b0}};
      buffer_switch_event <= 1'b0;
      switch_pending      <= 1'b0;
      error               <= 1'b0;
      rx_ready            <= 1'b0;
    end else begin
      state               <= state_nx;
      cnt                 <= cnt_nx;
      ch                  <= ch_nx;
      shift               <= shift_nx;
      write_data          <= write_data_nx;
      write_enable        <= write_enable_nx;
      buffer_switch_event <= bse_nx;
      switch_pending      <= pend_nx;
      error               <= err_nx;
      rx_ready            <= ready_nx;
    end
  end

endmodule
